// File: rtl/nor_tree_pipe.sv
// Pipelined WIDTH-input NOR reduction built from 3-input OR levels, with valid/ready flow control.
// Define NOR_TREE_PIPE_ACCUM_EN to enable multi-beat frame accumulation (one result per frame).
module nor_tree_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic             IN_VALID,
    input  logic             IN_LAST,
    output logic             IN_READY,
    output logic             Y,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    function automatic int clog3(input int n);
        int l;
        int p;
        l = 1;
        p = 3;
        while (p < n) begin
            p = p * 3;
            l = l + 1;
        end
        return l;
    endfunction

    function automatic int pow3(input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) begin
            r = r * 3;
        end
        return r;
    endfunction

    localparam int LEVELS = clog3(WIDTH);

    // Tree level reached by the data held in register stage s (stage 0 is the raw input).
    function automatic int lvl(input int s);
        return (LEVELS * s + STAGES - 1) / STAGES;
    endfunction

    logic advance;
    assign advance  = !OUT_VALID || OUT_READY;
    assign IN_READY = !RST && advance;

    // Stage gi holds 3^(LEVELS-lvl(gi)) partial ORs; collapsing k levels at once is an OR over 3^k bits.
    for (genvar gi = 0; gi < STAGES; gi++) begin : stg
        localparam int W = pow3(LEVELS - lvl(gi));
        logic [W-1:0] data;
        logic         vld;
`ifdef NOR_TREE_PIPE_ACCUM_EN
        logic         lst;
`endif
        if (gi == 0) begin : g_in
            assign data = W'(A);
            assign vld  = IN_VALID;
`ifdef NOR_TREE_PIPE_ACCUM_EN
            assign lst  = IN_LAST;
`endif
        end else begin : g_reg
            localparam int G = pow3(lvl(gi) - lvl(gi - 1));
            logic [W-1:0] data_next;
            for (genvar gj = 0; gj < W; gj++) begin : grp
                assign data_next[gj] = |stg[gi-1].data[gj*G +: G];
            end
            always_ff @(posedge CLK) begin
                if (RST) begin
                    vld <= 1'b0;
                end else if (advance) begin
                    vld  <= stg[gi-1].vld;
                    data <= data_next;
`ifdef NOR_TREE_PIPE_ACCUM_EN
                    lst  <= stg[gi-1].lst;
`endif
                end
            end
        end
    end

    logic beat_or;
    logic y_reg;
    logic out_valid_reg;
    assign beat_or   = |stg[STAGES-1].data;
    assign Y         = y_reg;
    assign OUT_VALID = out_valid_reg;

`ifdef NOR_TREE_PIPE_ACCUM_EN
    logic acc_reg;
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_reg <= 1'b0;
            y_reg         <= 1'b0;
            acc_reg       <= 1'b0;
        end else if (advance) begin
            if (stg[STAGES-1].vld) begin
                if (!stg[STAGES-1].lst) begin
                    acc_reg       <= acc_reg | beat_or;
                    out_valid_reg <= 1'b0;
                end else begin
                    y_reg         <= ~(acc_reg | beat_or);
                    out_valid_reg <= 1'b1;
                    acc_reg       <= 1'b0;
                end
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = IN_LAST;
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_reg <= 1'b0;
            y_reg         <= 1'b0;
        end else if (advance) begin
            if (stg[STAGES-1].vld) begin
                y_reg         <= ~beat_or;
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nor_tree_pipe.sv
// Bench for nor_tree_pipe: three configurations (32/2, 5/4, 1/1) checked against a frame-level scoreboard.
// Accumulate-mode steps are included when NOR_TREE_PIPE_ACCUM_EN is defined.
module tb_nor_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] a0;
    logic [4:0]  a1;
    logic [0:0]  a2;
    logic [2:0]  vld, lst, ordy;
    wire  [2:0]  irdy, yv, ovld;

    nor_tree_pipe #(.WIDTH(32), .STAGES(2)) u0 (
        .CLK(clk), .RST(rst), .A(a0), .IN_VALID(vld[0]), .IN_LAST(lst[0]),
        .IN_READY(irdy[0]), .Y(yv[0]), .OUT_VALID(ovld[0]), .OUT_READY(ordy[0]));
    nor_tree_pipe #(.WIDTH(5), .STAGES(4)) u1 (
        .CLK(clk), .RST(rst), .A(a1), .IN_VALID(vld[1]), .IN_LAST(lst[1]),
        .IN_READY(irdy[1]), .Y(yv[1]), .OUT_VALID(ovld[1]), .OUT_READY(ordy[1]));
    nor_tree_pipe #(.WIDTH(1), .STAGES(1)) u2 (
        .CLK(clk), .RST(rst), .A(a2), .IN_VALID(vld[2]), .IN_LAST(lst[2]),
        .IN_READY(irdy[2]), .Y(yv[2]), .OUT_VALID(ovld[2]), .OUT_READY(ordy[2]));

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit expq [3][$];
    bit frame_or [3];
    int ntake [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, then update the reference model and check.
    task automatic step();
        logic        rst_s;
        logic [2:0]  acc_s, take_s, y_s, ov_s, ordy_s, lst_s;
        logic [31:0] a_s [3];
        @(negedge clk);
        rst_s  = rst;
        a_s[0] = a0;
        a_s[1] = {27'b0, a1};
        a_s[2] = {31'b0, a2};
        y_s    = yv;
        ov_s   = ovld;
        ordy_s = ordy;
        lst_s  = lst;
        for (int k = 0; k < 3; k++) begin
            acc_s[k]  = vld[k] && irdy[k];
            take_s[k] = ovld[k] && ordy[k];
            chk($sformatf("in_ready_rule_%0d", k), {31'b0, irdy[k]}, {31'b0, !rst && (!ovld[k] || ordy[k])});
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (rst_s) begin
                expq[k].delete();
                frame_or[k] = 1'b0;
                chk($sformatf("reset_ov_%0d", k), {31'b0, ovld[k]}, 32'd0);
                chk($sformatf("reset_y_%0d", k), {31'b0, yv[k]}, 32'd0);
            end else begin
                if (take_s[k]) begin
                    chk($sformatf("result_expected_%0d", k), {31'b0, expq[k].size() != 0}, 32'd1);
                    if (expq[k].size() != 0) begin
                        chk($sformatf("result_y_%0d", k), {31'b0, y_s[k]}, {31'b0, expq[k].pop_front()});
                        ntake[k]++;
                    end
                end else if (ov_s[k]) begin
                    chk($sformatf("hold_ov_%0d", k), {31'b0, ovld[k]}, 32'd1);
                    if (expq[k].size() != 0)
                        chk($sformatf("hold_y_%0d", k), {31'b0, yv[k]}, {31'b0, expq[k][0]});
                end
                if (acc_s[k]) begin
                    bit bor;
                    bor = (a_s[k] != 0);
`ifdef NOR_TREE_PIPE_ACCUM_EN
                    if (!lst_s[k]) begin
                        frame_or[k] = frame_or[k] | bor;
                    end else begin
                        expq[k].push_back(~(frame_or[k] | bor));
                        frame_or[k] = 1'b0;
                    end
`else
                    expq[k].push_back(~bor);
`endif
                end
            end
        end
    endtask

    function automatic logic [31:0] rnd_a();
        case ($urandom_range(0, 2))
            0:       return 32'd0;
            1:       return 32'd1 << $urandom_range(0, 31);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int n0;
        rst = 1'b1; a0 = '0; a1 = '0; a2 = '0;
        vld = '0; lst = '0; ordy = 3'b111;
        repeat (3) step();
        chk("reset_in_ready", {29'b0, irdy}, 32'd0);
        chk("reset_out_valid", {29'b0, ovld}, 32'd0);
        chk("reset_y", {29'b0, yv}, 32'd0);
        rst = 1'b0;

        // 32/2: zero then one set bit, back to back
        a0 = 32'h0; vld = 3'b001; step();
        chk("t1_early_ov", {31'b0, ovld[0]}, 32'd0);
        a0 = 32'h0001_0000; step();
        chk("t1_ov_first", {31'b0, ovld[0]}, 32'd1);
        chk("t1_y_first", {31'b0, yv[0]}, 32'd1);
        vld = 3'b000; step();
        chk("t1_ov_second", {31'b0, ovld[0]}, 32'd1);
        chk("t1_y_second", {31'b0, yv[0]}, 32'd0);
        step();
        chk("t1_ov_idle", {31'b0, ovld[0]}, 32'd0);

        // 5/4: surplus delay stages, padding must not matter
        a1 = 5'h10; vld = 3'b010; step();
        vld = 3'b000; step(); step();
        chk("t2_early_ov", {31'b0, ovld[1]}, 32'd0);
        step();
        chk("t2_ov_a", {31'b0, ovld[1]}, 32'd1);
        chk("t2_y_a", {31'b0, yv[1]}, 32'd0);
        a1 = 5'h00; vld = 3'b010; step();
        vld = 3'b000; repeat (3) step();
        chk("t2_ov_b", {31'b0, ovld[1]}, 32'd1);
        chk("t2_y_b", {31'b0, yv[1]}, 32'd1);
        for (int b = 0; b < 5; b++) begin
            a1 = 5'(1 << b); vld = 3'b010; step();
        end
        a1 = 5'h00; step();
        vld = 3'b000; repeat (6) step();

        // 1/1: plain inverter with one register
        a2 = 1'b1; vld = 3'b100; step();
        chk("t6_ov_a", {31'b0, ovld[2]}, 32'd1);
        chk("t6_y_a", {31'b0, yv[2]}, 32'd0);
        a2 = 1'b0; step();
        chk("t6_ov_b", {31'b0, ovld[2]}, 32'd1);
        chk("t6_y_b", {31'b0, yv[2]}, 32'd1);
        vld = 3'b000; step();
        chk("t6_ov_idle", {31'b0, ovld[2]}, 32'd0);

        // Backpressure on 32/2
        ordy = 3'b110; vld = 3'b001;
        for (int i = 0; i < 4; i++) begin
            a0 = (i % 2 == 1) ? 32'h0040_0000 : 32'h0;
            step();
        end
        repeat (3) begin
            step();
            chk("t3_in_ready_low", {31'b0, irdy[0]}, 32'd0);
            chk("t3_ov_held", {31'b0, ovld[0]}, 32'd1);
        end
        ordy = 3'b111; vld = 3'b000;
        repeat (4) step();
        chk("t3_ov_drained", {31'b0, ovld[0]}, 32'd0);
        chk("t3_queue_drained", expq[0].size(), 32'd0);

`ifdef NOR_TREE_PIPE_ACCUM_EN
        // Frame of zeros, then a frame with one set bit
        n0 = ntake[0];
        a0 = 32'h0; vld = 3'b001; lst = 3'b000; step(); step();
        lst = 3'b001; step();
        vld = 3'b000; lst = 3'b000;
        chk("t4_no_partial_out", {31'b0, ovld[0]}, 32'd0);
        step();
        chk("t4_ov_f1", {31'b0, ovld[0]}, 32'd1);
        chk("t4_y_f1", {31'b0, yv[0]}, 32'd1);
        step();
        a0 = 32'h0; vld = 3'b001; step();
        a0 = 32'h4; step();
        a0 = 32'h0; lst = 3'b001; step();
        vld = 3'b000; lst = 3'b000; step();
        chk("t4_y_f2", {31'b0, yv[0]}, 32'd0);
        repeat (3) step();
        chk("t4_one_result_per_frame", ntake[0] - n0, 32'd2);

        // Partial frame discarded by reset
        n0 = ntake[0];
        a0 = 32'h8; vld = 3'b001; lst = 3'b000; step();
        vld = 3'b000; rst = 1'b1;
        #1;
        chk("t5_in_ready_in_rst", {31'b0, irdy[0]}, 32'd0);
        step();
        chk("t5_ov_rst", {31'b0, ovld[0]}, 32'd0);
        chk("t5_y_rst", {31'b0, yv[0]}, 32'd0);
        rst = 1'b0;
        a0 = 32'h0; vld = 3'b001; lst = 3'b001; step();
        vld = 3'b000; lst = 3'b000;
        chk("t5_no_early_out", {31'b0, ovld[0]}, 32'd0);
        step();
        chk("t5_ov", {31'b0, ovld[0]}, 32'd1);
        chk("t5_y", {31'b0, yv[0]}, 32'd1);
        step();
        chk("t5_single_result", ntake[0] - n0, 32'd1);
`endif

        // Random traffic, random backpressure and occasional reset
        for (int i = 0; i < 500; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            a0   = rnd_a();
            a1   = 5'(rnd_a());
            a2   = 1'(rnd_a());
            vld  = 3'($urandom() | $urandom());
            ordy = 3'($urandom() | $urandom());
            lst  = 3'($urandom() & $urandom());
            step();
        end
        rst = 1'b0; vld = 3'b000; ordy = 3'b111;
        repeat (8) step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("final_queue_%0d", k), expq[k].size(), 32'd0);
            chk($sformatf("final_ov_%0d", k), {31'b0, ovld[k]}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
